// File: rtl/ysyx_24080014_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080014_csr_pkg
// Description : Op encodings, machine CSR addresses and sequencer states
//               shared by the CSR/trap sequencer.
// Revision    : 1.0
// ============================================================================
package ysyx_24080014_csr_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WRITE2 = 3'd3,
        ST_RESP   = 3'd4
    } seq_state_e;

    localparam logic [11:0] c_mstatus = 12'h300;
    localparam logic [11:0] c_mtvec   = 12'h305;
    localparam logic [11:0] c_mepc    = 12'h341;
    localparam logic [11:0] c_mcause  = 12'h342;

    function automatic logic csr_addr_legal(input logic [11:0] addr);
        return (addr == c_mstatus) || (addr == c_mtvec) ||
               (addr == c_mepc)    || (addr == c_mcause);
    endfunction

    function automatic logic is_csrrx(input csr_op_e op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24080014_csr_seq.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080014_csr_seq
// Description : Sequences CSRRx/ECALL/MRET ops over the regfile CSR port and
//               returns the old CSR value and any PC redirect.
// Revision    : 1.0
// ============================================================================
import ysyx_24080014_csr_pkg::*;

module ysyx_24080014_csr_seq #(
    parameter int              XLEN         = 32,
    parameter bit              USE_A7_CAUSE = 1'b1,
    parameter logic [XLEN-1:0] ECALL_CAUSE  = XLEN'(11)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [11:0]     in_csr,
    input  logic [XLEN-1:0] in_src,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_a7,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd_data,
    output logic            out_rd_wen,
    output logic            out_redir,
    output logic [XLEN-1:0] out_redir_pc,
    output logic            out_illegal
);

    seq_state_e      r_state;
    csr_op_e         r_op;
    logic [11:0]     r_csr;
    logic [XLEN-1:0] r_src, r_pc, r_a7, r_old;
    logic            r_in_ready;
    logic [11:0]     r_csr_raddr;
    logic            r_csr_wen;
    logic [11:0]     r_csr_waddr;
    logic [XLEN-1:0] r_csr_wdata;
    logic            r_out_valid, r_out_rd_wen, r_out_redir, r_out_illegal;
    logic [XLEN-1:0] r_out_rd_data, r_out_redir_pc;

    csr_op_e         w_op_in;
    logic            w_accept;
    logic [XLEN-1:0] w_rmw_data;
    logic [XLEN-1:0] w_cause;

    assign w_op_in  = csr_op_e'(in_op);
    assign w_accept = in_valid && r_in_ready;
    assign w_cause  = USE_A7_CAUSE ? r_a7 : ECALL_CAUSE;

    // New CSR value, computed against the live read data during READ
    always_comb begin
        w_rmw_data = r_src;
        case (r_op)
            OP_CSRRS: w_rmw_data = csr_rdata | r_src;
            OP_CSRRC: w_rmw_data = csr_rdata & ~r_src;
            default:  w_rmw_data = r_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_NONE;
            r_csr          <= '0;
            r_src          <= '0;
            r_pc           <= '0;
            r_a7           <= '0;
            r_old          <= '0;
            r_in_ready     <= 1'b1;
            r_csr_raddr    <= '0;
            r_csr_wen      <= 1'b0;
            r_csr_waddr    <= '0;
            r_csr_wdata    <= '0;
            r_out_valid    <= 1'b0;
            r_out_rd_data  <= '0;
            r_out_rd_wen   <= 1'b0;
            r_out_redir    <= 1'b0;
            r_out_redir_pc <= '0;
            r_out_illegal  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op_in;
                        r_csr <= in_csr;
                        r_src <= in_src;
                        r_pc  <= in_pc;
                        r_a7  <= in_a7;
                        // NONE and unencoded ops are consumed without a response
                        if (is_csrrx(w_op_in) || w_op_in == OP_ECALL || w_op_in == OP_MRET) begin
                            r_state    <= ST_READ;
                            r_in_ready <= 1'b0;
                            if (is_csrrx(w_op_in))
                                r_csr_raddr <= in_csr;
                            else if (w_op_in == OP_ECALL)
                                r_csr_raddr <= c_mtvec;
                            else
                                r_csr_raddr <= c_mepc;
                        end
                    end
                end
                ST_READ: begin
                    r_old       <= csr_rdata;
                    r_csr_raddr <= '0;
                    if (is_csrrx(r_op)) begin
                        if (!csr_addr_legal(r_csr)) begin
                            r_state       <= ST_RESP;
                            r_out_valid   <= 1'b1;
                            r_out_illegal <= 1'b1;
                        end else begin
                            r_state     <= ST_WRITE;
                            r_csr_wen   <= (r_op == OP_CSRRW) || (r_src != '0);
                            r_csr_waddr <= r_csr;
                            r_csr_wdata <= w_rmw_data;
                        end
                    end else if (r_op == OP_ECALL) begin
                        r_state     <= ST_WRITE;
                        r_csr_wen   <= 1'b1;
                        r_csr_waddr <= c_mepc;
                        r_csr_wdata <= r_pc;
                    end else begin
                        r_state        <= ST_RESP;
                        r_out_valid    <= 1'b1;
                        r_out_redir    <= 1'b1;
                        r_out_redir_pc <= csr_rdata;
                    end
                end
                ST_WRITE: begin
                    if (r_op == OP_ECALL) begin
                        r_state     <= ST_WRITE2;
                        r_csr_wen   <= 1'b1;
                        r_csr_waddr <= c_mcause;
                        r_csr_wdata <= w_cause;
                    end else begin
                        r_state       <= ST_RESP;
                        r_csr_wen     <= 1'b0;
                        r_csr_waddr   <= '0;
                        r_csr_wdata   <= '0;
                        r_out_valid   <= 1'b1;
                        r_out_rd_data <= r_old;
                        r_out_rd_wen  <= 1'b1;
                    end
                end
                ST_WRITE2: begin
                    r_state        <= ST_RESP;
                    r_csr_wen      <= 1'b0;
                    r_csr_waddr    <= '0;
                    r_csr_wdata    <= '0;
                    r_out_valid    <= 1'b1;
                    r_out_redir    <= 1'b1;
                    r_out_redir_pc <= r_old;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        r_state        <= ST_IDLE;
                        r_in_ready     <= 1'b1;
                        r_out_valid    <= 1'b0;
                        r_out_rd_data  <= '0;
                        r_out_rd_wen   <= 1'b0;
                        r_out_redir    <= 1'b0;
                        r_out_redir_pc <= '0;
                        r_out_illegal  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign csr_raddr    = r_csr_raddr;
    assign csr_wen      = r_csr_wen;
    assign csr_waddr    = r_csr_waddr;
    assign csr_wdata    = r_csr_wdata;
    assign out_valid    = r_out_valid;
    assign out_rd_data  = r_out_rd_data;
    assign out_rd_wen   = r_out_rd_wen;
    assign out_redir    = r_out_redir;
    assign out_redir_pc = r_out_redir_pc;
    assign out_illegal  = r_out_illegal;

endmodule
`default_nettype wire
